msk_refresh_rnd_feeder: RTL and testbench
=========================================

// Module: msk_refresh_rnd_feeder
// PURPOSE
//  Upstream randomness stage for the masked bitwise refresh tree.
//  - Gathers a narrow PRNG stream (IN_W bits/beat, valid/ready) into one full refresh word of (d-1)*BITS bits.
//  - Presents that word on a valid/ready port that drives the refresh tree's rnd input.
//  - Guarantees each random bit is delivered to exactly one refresh: no reuse, no loss.
// PARAMETERS
//  d     2   number of shares; refresh consumes d-1 random bits per data bit
//  BITS  16  data bits refreshed per operation
//  IN_W  32  PRNG beat width
//  (derived) RW = (d-1)*BITS word width; NB = ceil(RW/IN_W) beats per word
// PORTS
//  clk           in   1     clock; all state on rising edge
//  rst           in   1     synchronous reset, active-low (asserted when 0)
//  in_rnd_data   in   IN_W  PRNG beat
//  in_rnd_valid  in   1     PRNG beat valid
//  in_rnd_ready  out  1     feeder accepts the beat this cycle
//  rnd_out       out  RW    random word, bit layout as the refresh tree's rnd (bit i: [i*(d-1) +: d-1])
//  rnd_valid     out  1     rnd_out holds a complete, unused word
//  rnd_ready     in   1     consumer takes rnd_out this cycle
// BEHAVIOUR
//  Reset (rst==0 at a clock edge):
//  - All outputs 0.
//  - Beat counter = 0; buffer(s) empty; buffer contents zeroed.
//  - Beats in flight are discarded.
//  - in_rnd_ready is 0 during reset and 1 in the first cycle after.
//  Packing:
//  - Beat k (0..NB-1) is written to word bits [k*IN_W +: IN_W].
//  - On the last beat, bits at index >= RW are dropped.
//  - The counter wraps NB-1 -> 0 when the word completes.
//  Handshakes:
//  - A beat transfers when in_rnd_valid & in_rnd_ready.
//  - A word transfers when rnd_valid & rnd_ready.
//  - in_rnd_ready and rnd_valid are registered outputs.
//  - in_rnd_ready does not depend combinationally on rnd_ready.
//  - rnd_out and rnd_valid stay stable while rnd_valid=1 and rnd_ready=0.
//  FSM without prefetch:
//  - FILL:  in_rnd_ready=1, rnd_valid=0. The last beat moves the FSM to FULL next cycle.
//  - FULL:  in_rnd_ready=0, rnd_valid=1. A word transfer moves the FSM to FILL.
//  - The word register is not cleared on a transfer; stale bits are overwritten by the next fill.
//  - Latency: the word is valid the cycle after the NB-th beat is accepted.
//  - Maximum throughput is one word per NB+1 cycles.
//  Boundaries:
//  - rnd_ready while rnd_valid=0 is ignored.
//  - in_rnd_valid while in_rnd_ready=0 is ignored; the producer must hold the beat.
//  - NB==1: FILL lasts a single accepted beat.
//  - Reset mid-fill discards the partial word. No partial word is ever presented.
// CONFIGURATION
//  MSKREFRESH_RND_PREFETCH_EN
//  - Defined: adds a second word buffer (staging + output).
//    - Filling continues into staging while the output word waits.
//    - in_rnd_ready=0 only when both buffers hold complete words.
//    - On a word transfer, a complete staging word moves to the output in the same edge; rnd_valid stays 1.
//    - Steady throughput is one word per NB cycles.
//    - Word order is strictly FIFO.
//  - Undefined: the single-buffer FSM above; no staging register is instantiated.
// TESTING
//  Parameters: d=3, BITS=16, IN_W=8 (RW=32, NB=4).
//  T1 Beats 0x11,0x22,0x33,0x44 with rnd_ready=0
//     -> rnd_valid=1 one cycle after the 4th beat; rnd_out=0x44332211; in_rnd_ready=0 (no prefetch).
//  T2 From T1, hold rnd_ready=0 for 10 cycles, then pulse it
//     -> rnd_out stable all 10 cycles; exactly one transfer; rnd_valid=0 next cycle; next word starts at beat 0.
//  T3 Reset (rst=0) after 2 beats, then beats 0xAA,0xBB,0xCC,0xDD
//     -> rnd_out=0xDDCCBBAA; the pre-reset beats never appear.
//  T4 Random in_rnd_valid and rnd_ready gaps, 1000 words
//     -> scoreboard: the consumed word stream equals the concatenated beat stream, with no duplicate and no drop.
//  T5 PREFETCH_EN, in_rnd_valid=1 always, rnd_ready=1 always
//     -> one word every 4 cycles; words in order.
//  T6 PREFETCH_EN, rnd_ready=0
//     -> in_rnd_ready falls after exactly 8 beats; releasing rnd_ready gives back-to-back rnd_valid cycles.

Source files
------------

// File: rtl/msk_refresh_rnd_feeder.sv
// Packs a narrow PRNG beat stream into full refresh-tree random words behind a valid/ready port.
// Optional second word buffer enabled by defining MSKREFRESH_RND_PREFETCH_EN.
module msk_refresh_rnd_feeder #(
    parameter int d    = 2,
    parameter int BITS = 16,
    parameter int IN_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          in_rnd_data,
    input  logic                     in_rnd_valid,
    output logic                     in_rnd_ready,
    output logic [(d-1)*BITS-1:0]    rnd_out,
    output logic                     rnd_valid,
    input  logic                     rnd_ready
);
    localparam int RW = (d - 1) * BITS;
    localparam int NB = (RW + IN_W - 1) / IN_W;
    localparam int BW = NB * IN_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] cnt_r;
    logic [BW-1:0] fill_r;
    logic [BW-1:0] fill_word_s;
    logic          in_rdy_r;
    logic          out_vld_r;
    logic          beat_acc_s;
    logic          last_beat_s;
    logic          word_xfer_s;

    assign beat_acc_s   = in_rnd_valid & in_rdy_r;
    assign last_beat_s  = beat_acc_s & (cnt_r == CW'(NB - 1));
    assign word_xfer_s  = out_vld_r & rnd_ready;
    assign in_rnd_ready = in_rdy_r;
    assign rnd_valid    = out_vld_r;

    // Fill buffer with the accepted beat merged into its slot
    always_comb begin
        fill_word_s = fill_r;
        if (beat_acc_s) begin
            fill_word_s[int'(cnt_r)*IN_W +: IN_W] = in_rnd_data;
        end else begin
            fill_word_s = fill_r;
        end
    end

    // Beat counter, wraps when a word completes
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (last_beat_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (beat_acc_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fill buffer register; stale bits are simply overwritten by the next fill
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_r <= {BW{1'b0}};
        end else begin
            fill_r <= fill_word_s;
        end
    end

    // Last-beat bits above the word width are dropped
    generate
        if (BW > RW) begin : g_drop
            logic unused_drop_s;
            assign unused_drop_s = ^fill_r[BW-1:RW];
        end
    endgenerate

`ifdef MSKREFRESH_RND_PREFETCH_EN
    logic          stg_full_r;
    logic          stg_full_next_s;
    logic          out_vld_next_s;
    logic          load_fill_s;
    logic          load_stg_s;
    logic [RW-1:0] out_r;

    assign rnd_out = out_r;

    // Decide where a completed word goes and when the staging word advances
    always_comb begin
        stg_full_next_s = stg_full_r;
        out_vld_next_s  = out_vld_r;
        load_fill_s     = 1'b0;
        load_stg_s      = 1'b0;
        if (last_beat_s) begin
            if (!out_vld_r || word_xfer_s) begin
                load_fill_s    = 1'b1;
                out_vld_next_s = 1'b1;
            end else begin
                stg_full_next_s = 1'b1;
            end
        end else if (word_xfer_s) begin
            if (stg_full_r) begin
                load_stg_s      = 1'b1;
                stg_full_next_s = 1'b0;
            end else begin
                out_vld_next_s = 1'b0;
            end
        end else begin
            stg_full_next_s = stg_full_r;
        end
    end

    // Output word, flags and registered handshakes
    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_full_r <= 1'b0;
            out_vld_r  <= 1'b0;
            in_rdy_r   <= 1'b0;
            out_r      <= {RW{1'b0}};
        end else begin
            stg_full_r <= stg_full_next_s;
            out_vld_r  <= out_vld_next_s;
            in_rdy_r   <= ~(stg_full_next_s & out_vld_next_s);
            if (load_fill_s) begin
                out_r <= fill_word_s[RW-1:0];
            end else if (load_stg_s) begin
                out_r <= fill_r[RW-1:0];
            end else begin
                out_r <= out_r;
            end
        end
    end
`else
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t state_r;
    state_t state_next_s;

    assign rnd_out = fill_r[RW-1:0];

    // Next state: fill until the last beat, then hold until consumed
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (last_beat_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (word_xfer_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // State register with handshakes registered from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_FILL;
            in_rdy_r  <= 1'b0;
            out_vld_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            in_rdy_r  <= (state_next_s == ST_FILL);
            out_vld_r <= (state_next_s == ST_FULL);
        end
    end
`endif

endmodule

// File: tb/tb_msk_refresh_rnd_feeder.sv
// Randomized bench for msk_refresh_rnd_feeder (d=3, BITS=16, IN_W=8) against a beat-queue reference model.
module tb_msk_refresh_rnd_feeder;
    localparam int D    = 3;
    localparam int BITS = 16;
    localparam int IN_W = 8;
    localparam int RW   = (D - 1) * BITS;
    localparam int NB   = (RW + IN_W - 1) / IN_W;
`ifdef MSKREFRESH_RND_PREFETCH_EN
    localparam int CAP  = 2 * NB;
`else
    localparam int CAP  = NB;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [IN_W-1:0] in_rnd_data = '0;
    logic            in_rnd_valid = 1'b0;
    logic            in_rnd_ready;
    logic [RW-1:0]   rnd_out;
    logic            rnd_valid;
    logic            rnd_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Every accepted beat not yet consumed, oldest first
    logic [IN_W-1:0] beat_q[$];

    msk_refresh_rnd_feeder #(.d(D), .BITS(BITS), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst),
        .in_rnd_data(in_rnd_data), .in_rnd_valid(in_rnd_valid), .in_rnd_ready(in_rnd_ready),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] head_word();
        logic [RW-1:0] w = '0;
        for (int k = 0; k < NB; k++) w |= RW'(beat_q[k]) << (k * IN_W);
        return w;
    endfunction

    // One clock: drive, observe handshakes mid-cycle, update the model, return #1 after the edge
    task automatic cycle(input logic iv, input logic [IN_W-1:0] dat, input logic rr,
                         output logic bt, output logic wt,
                         output logic [RW-1:0] seen, output logic [RW-1:0] expw, output logic ok);
        in_rnd_valid = iv;
        in_rnd_data  = dat;
        rnd_ready    = rr;
        @(negedge clk);
        bt = iv & in_rnd_ready;
        wt = rnd_valid & rr;
        seen = rnd_out;
        expw = '0;
        ok = 1'b1;
        if (!rst) begin
            beat_q.delete();
            bt = 1'b0;
            wt = 1'b0;
        end else begin
            if (wt) begin
                ok = (beat_q.size() >= NB);
                if (ok) begin
                    expw = head_word();
                    for (int k = 0; k < NB; k++) void'(beat_q.pop_front());
                end
            end
            if (bt) beat_q.push_back(dat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        rst = 1'b0;
        repeat (3) cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
        vectors++;
        if (in_rnd_ready !== 1'b0 || rnd_valid !== 1'b0 || rnd_out !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b out=%h, required 0 0 0", in_rnd_ready, rnd_valid, rnd_out);
        end
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
        vectors++;
        if (in_rnd_ready !== 1'b1 || rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1 0", in_rnd_ready, rnd_valid);
        end
    endtask

    task automatic fill_word(input logic [IN_W-1:0] b0, input logic [IN_W-1:0] b1,
                             input logic [IN_W-1:0] b2, input logic [IN_W-1:0] b3, input string nm);
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        logic [IN_W-1:0] bb[4];
        bb = '{b0, b1, b2, b3};
        for (int k = 0; k < NB; k++) begin
            cycle(1'b1, bb[k], 1'b0, bt, wt, s, e, ok);
            vectors++;
            if (bt !== 1'b1 || rnd_valid !== (k == NB - 1)) begin
                miscompares++;
                $display("FAIL %s_beat%0d: taken=%b valid=%b, required 1 %b", nm, k, bt, rnd_valid, k == NB - 1);
            end
        end
        in_rnd_valid = 1'b0;
    endtask

    task automatic consume(input logic [RW-1:0] req, input string nm);
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        cycle(1'b0, '0, 1'b1, bt, wt, s, e, ok);
        vectors++;
        if (wt !== 1'b1 || !ok || s !== req || e !== req || rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_consume: taken=%b word=%h model=%h valid_after=%b, required 1 %h %h 0",
                     nm, wt, s, e, rnd_valid, req, req);
        end
        rnd_ready = 1'b0;
    endtask

    task automatic test_fill();
        fill_word(8'h11, 8'h22, 8'h33, 8'h44, "t1");
        vectors++;
`ifdef MSKREFRESH_RND_PREFETCH_EN
        if (rnd_out !== 32'h44332211 || in_rnd_ready !== 1'b1) begin
`else
        if (rnd_out !== 32'h44332211 || in_rnd_ready !== 1'b0) begin
`endif
            miscompares++;
            $display("FAIL t1_word: out=%h ready=%b, required 44332211 and CAP=%0d ready", rnd_out, in_rnd_ready, CAP);
        end
    endtask

    task automatic test_hold();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
            vectors++;
            if (wt !== 1'b0 || rnd_valid !== 1'b1 || rnd_out !== 32'h44332211) begin
                miscompares++;
                $display("FAIL t2_hold%0d: taken=%b valid=%b out=%h, required 0 1 44332211", i, wt, rnd_valid, rnd_out);
            end
        end
        consume(32'h44332211, "t2");
        fill_word(8'h01, 8'h02, 8'h03, 8'h04, "t2_next");
        consume(32'h04030201, "t2_next");
    endtask

    task automatic test_reset_midfill();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        cycle(1'b1, 8'h55, 1'b0, bt, wt, s, e, ok);
        cycle(1'b1, 8'h66, 1'b0, bt, wt, s, e, ok);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
        vectors++;
        if (in_rnd_ready !== 1'b0 || rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_in_reset: ready=%b valid=%b, required 0 0", in_rnd_ready, rnd_valid);
        end
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
        fill_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, "t3");
        vectors++;
        if (rnd_out !== 32'hDDCCBBAA) begin
            miscompares++;
            $display("FAIL t3_word: out=%h, required ddccbbaa", rnd_out);
        end
        consume(32'hDDCCBBAA, "t3");
    endtask

    task automatic test_random();
        logic bt, wt, ok, iv, rr;
        logic [RW-1:0] s, e;
        logic [IN_W-1:0] pend;
        int words = 0;
        int cyc = 0;
        pend = IN_W'($urandom);
        while (words < 1000 && cyc < 40000) begin
            iv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 6);
            cycle(iv, pend, rr, bt, wt, s, e, ok);
            cyc++;
            if (bt) pend = IN_W'($urandom);
            if (wt) begin
                words++;
                vectors++;
                if (!ok || s !== e) begin
                    miscompares++;
                    $display("FAIL t4_word%0d: got=%h, required %h (complete=%b)", words, s, e, ok);
                end
            end
            vectors++;
            if (rnd_valid !== (beat_q.size() >= NB) || in_rnd_ready !== (beat_q.size() < CAP) ||
                (rnd_valid === 1'b1 && rnd_out !== head_word())) begin
                miscompares++;
                $display("FAIL t4_state cyc%0d: valid=%b ready=%b out=%h, pending beats=%0d",
                         cyc, rnd_valid, in_rnd_ready, rnd_out, beat_q.size());
            end
        end
        vectors++;
        if (words < 1000) begin
            miscompares++;
            $display("FAIL t4_timeout: words=%0d, required 1000", words);
        end
        rnd_ready = 1'b0;
        in_rnd_valid = 1'b0;
    endtask

`ifdef MSKREFRESH_RND_PREFETCH_EN
    task automatic restart();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, bt, wt, s, e, ok);
    endtask

    task automatic test_back_to_back();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        int last = -1;
        int words = 0;
        logic [IN_W-1:0] cnt = 8'h00;
        restart();
        for (int c = 0; c < 60; c++) begin
            cycle(1'b1, cnt, 1'b1, bt, wt, s, e, ok);
            if (bt) cnt = cnt + 8'h01;
            if (wt) begin
                vectors++;
                if (!ok || s !== e || (last >= 0 && c - last != NB)) begin
                    miscompares++;
                    $display("FAIL t5_word c%0d: got=%h want=%h gap=%0d, required gap %0d", c, s, e, c - last, NB);
                end
                last = c;
                words++;
            end
        end
        vectors++;
        if (words < 12) begin
            miscompares++;
            $display("FAIL t5_count: words=%0d, required >=12", words);
        end
        in_rnd_valid = 1'b0;
        rnd_ready = 1'b0;
    endtask

    task automatic test_prefetch_stall();
        logic bt, wt, ok;
        logic [RW-1:0] s, e;
        int beats = 0;
        restart();
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, IN_W'(8'h30 + beats), 1'b0, bt, wt, s, e, ok);
            if (bt) beats++;
        end
        vectors++;
        if (beats != 2 * NB || in_rnd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_stall: beats=%0d ready=%b, required %0d 0", beats, in_rnd_ready, 2 * NB);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, 1'b1, bt, wt, s, e, ok);
            vectors++;
            if (wt !== 1'b1 || !ok || s !== e || rnd_valid !== (i == 0)) begin
                miscompares++;
                $display("FAIL t6_drain%0d: taken=%b got=%h want=%h valid=%b", i, wt, s, e, rnd_valid);
            end
        end
        rnd_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_reset_midfill();
        test_random();
`ifdef MSKREFRESH_RND_PREFETCH_EN
        test_back_to_back();
        test_prefetch_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
